// File: rtl/fft_writeback_drain.sv
// fft_writeback_drain
//   Writeback-stage drain unit. An entry accepted from the writeback pipe
//   register can write the register file and/or the FFT sample buffer. A
//   register-file write is issued one cycle after acceptance. An FFT write
//   latches the whole word. The word is then drained one DATAW sample at a
//   time over a valid/ready handshake. While draining, stall_out holds the
//   writeback pipe register, so its entry is accepted in the first idle cycle.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   valid_in                : writeback entry present
//   fft_wr_en_in            : entry writes the FFT buffer
//   reg_wr_en_in            : entry writes the register file
//   wr_reg_in, data_in      : destination register and writeback word
//   addr_in                 : FFT buffer base sample address
//   stall_out               : high while a word is draining
//   rf_wr_en/reg/data       : register-file write port (one-cycle strobe)
//   fft_valid/ready         : sample handshake toward the FFT buffer
//   fft_addr/data/last      : sample address, sample data, final-sample flag
//   words_done              : count of fully drained FFT words (wraps)
module fft_writeback_drain #(
  parameter int INW   = 512,
  parameter int DATAW = 16,
  parameter int ADDRW = 32,
  parameter int REGW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             fft_wr_en_in,
  input  logic             reg_wr_en_in,
  input  logic [REGW-1:0]  wr_reg_in,
  input  logic [ADDRW-1:0] addr_in,
  input  logic [INW-1:0]   data_in,
  output logic             stall_out,
  output logic             rf_wr_en,
  output logic [REGW-1:0]  rf_wr_reg,
  output logic [INW-1:0]   rf_wr_data,
  output logic             fft_valid,
  input  logic             fft_ready,
  output logic [ADDRW-1:0] fft_addr,
  output logic [DATAW-1:0] fft_data,
  output logic             fft_last,
  output logic [15:0]      words_done
);

  localparam int NS   = INW / DATAW;
  localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDXW-1:0]  r_idx;
  logic [INW-1:0]   r_word;
  logic [ADDRW-1:0] r_base;
  logic [15:0]      r_words_done;
  logic             r_rf_wr_en;
  logic [REGW-1:0]  r_rf_wr_reg;
  logic [INW-1:0]   r_rf_wr_data;

  logic             w_accept;
  logic             w_hs;
  logic             w_last;
  logic [31:0]      w_bitpos;
  logic [INW-1:0]   w_shifted;

  // An entry is only looked at while idle; in DRAIN the pipe is stalled.
  assign w_accept = (r_state == IDLE) && valid_in;
  assign w_last   = (r_state == DRAIN) && (r_idx == IDXW'(NS - 1));
  assign w_hs     = (r_state == DRAIN) && fft_ready;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && fft_wr_en_in) w_state_nxt = DRAIN;
      DRAIN:   if (w_hs && w_last)           w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- accept / drain datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_word       <= '0;
      r_base       <= '0;
      r_words_done <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_reg  <= '0;
      r_rf_wr_data <= '0;
    end else begin
      r_rf_wr_en <= 1'b0;
      if (w_accept) begin
        if (reg_wr_en_in) begin
          r_rf_wr_en   <= 1'b1;
          r_rf_wr_reg  <= wr_reg_in;
          r_rf_wr_data <= data_in;
        end
        if (fft_wr_en_in) begin
          r_word <= data_in;
          r_base <= addr_in;
          r_idx  <= '0;
        end
      end
      if (w_hs) begin
        if (w_last) begin
          r_idx        <= '0;
          r_words_done <= r_words_done + 16'd1;
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  // ---- outputs ----
  // Sample selection depends only on registered idx/word, so the offered
  // sample is stable for as long as fft_ready stays low.
  always_comb begin
    w_bitpos  = 32'(r_idx) * 32'(DATAW);
    w_shifted = r_word >> w_bitpos;
    stall_out = (r_state == DRAIN);
    fft_valid = (r_state == DRAIN);
    fft_last  = w_last;
    fft_data  = w_shifted[DATAW-1:0];
    fft_addr  = r_base + ADDRW'(r_idx);
  end

  assign rf_wr_en   = r_rf_wr_en;
  assign rf_wr_reg  = r_rf_wr_reg;
  assign rf_wr_data = r_rf_wr_data;
  assign words_done = r_words_done;

endmodule

// File: tb/tb_fft_writeback_drain.sv
module tb_fft_writeback_drain;

  localparam int INW   = 512;
  localparam int DATAW = 16;
  localparam int ADDRW = 32;
  localparam int REGW  = 3;
  localparam int NS    = INW / DATAW;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_in;
  logic             fft_wr_en_in;
  logic             reg_wr_en_in;
  logic [REGW-1:0]  wr_reg_in;
  logic [ADDRW-1:0] addr_in;
  logic [INW-1:0]   data_in;
  logic             stall_out;
  logic             rf_wr_en;
  logic [REGW-1:0]  rf_wr_reg;
  logic [INW-1:0]   rf_wr_data;
  logic             fft_valid;
  logic             fft_ready;
  logic [ADDRW-1:0] fft_addr;
  logic [DATAW-1:0] fft_data;
  logic             fft_last;
  logic [15:0]      words_done;

  fft_writeback_drain #(.INW(INW), .DATAW(DATAW), .ADDRW(ADDRW), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .fft_wr_en_in(fft_wr_en_in),
    .reg_wr_en_in(reg_wr_en_in), .wr_reg_in(wr_reg_in), .addr_in(addr_in),
    .data_in(data_in), .stall_out(stall_out), .rf_wr_en(rf_wr_en),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .fft_valid(fft_valid),
    .fft_ready(fft_ready), .fft_addr(fft_addr), .fft_data(fft_data),
    .fft_last(fft_last), .words_done(words_done)
  );

  always #5 clk = ~clk;

  // Reference model: pending samples of the word being drained, plus the
  // visible register-file port and the completed-word counter.
  typedef struct packed {
    logic [ADDRW-1:0] a;
    logic [DATAW-1:0] d;
    logic             l;
  } smp_t;

  smp_t             q[$];
  logic             m_rf_en;
  logic [REGW-1:0]  m_rf_reg;
  logic [INW-1:0]   m_rf_data;
  logic [15:0]      m_words;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [INW-1:0] act, input logic [INW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("stall_out", stall_out, q.size() != 0);
    chk("fft_valid", fft_valid, q.size() != 0);
    chk("rf_wr_en", rf_wr_en, m_rf_en);
    chk("rf_wr_reg", rf_wr_reg, m_rf_reg);
    chk("rf_wr_data", rf_wr_data, m_rf_data);
    chk("words_done", words_done, m_words);
    if (q.size() != 0) begin
      chk("fft_addr", fft_addr, q[0].a);
      chk("fft_data", fft_data, q[0].d);
      chk("fft_last", fft_last, q[0].l);
    end else begin
      chk("fft_last_idle", fft_last, 1'b0);
    end
  endtask

  // Apply one cycle of inputs, advance the model over the coming edge,
  // then check the DUT half a cycle after that edge.
  task automatic step(input logic v, input logic fe, input logic re,
                      input logic [REGW-1:0] rg, input logic [ADDRW-1:0] ad,
                      input logic [INW-1:0] dt, input logic rdy, input logic r);
    smp_t s;
    valid_in = v; fft_wr_en_in = fe; reg_wr_en_in = re; wr_reg_in = rg;
    addr_in = ad; data_in = dt; fft_ready = rdy; rst = r;
    if (r) begin
      q.delete();
      m_rf_en = 1'b0; m_rf_reg = '0; m_rf_data = '0; m_words = '0;
    end else begin
      m_rf_en = 1'b0;
      if (q.size() == 0) begin
        if (v) begin
          if (re) begin
            m_rf_en = 1'b1; m_rf_reg = rg; m_rf_data = dt;
          end
          if (fe) begin
            for (int k = 0; k < NS; k++) begin
              s.a = ad + ADDRW'(k);
              s.d = DATAW'(dt >> (k * DATAW));
              s.l = (k == NS - 1);
              q.push_back(s);
            end
          end
        end
      end else if (rdy) begin
        s = q.pop_front();
        if (s.l) m_words = m_words + 16'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  // mode 0: always ready, mode 1: ready pattern 1,0,0,..., mode 2: random
  task automatic drain_run(input int mode);
    int guard = 0;
    logic rdy;
    while (q.size() != 0 && guard < 1000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 3 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      idle(rdy);
      guard++;
    end
  endtask

  function automatic logic [INW-1:0] rand_word();
    logic [INW-1:0] w;
    for (int i = 0; i < INW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [INW-1:0] ramp_word();
    logic [INW-1:0] w;
    for (int k = 0; k < NS; k++) w[k*DATAW +: DATAW] = DATAW'(k);
    return w;
  endfunction

  logic [INW-1:0] w_a5;
  logic [INW-1:0] w_b;
  int stall_cnt;

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 3'd7, 32'h55, rand_word(), 1'b1, 1'b1);
    idle(1'b0);

    // Register-only entry
    w_a5 = {(INW/8){8'hA5}};
    step(1'b1, 1'b0, 1'b1, 3'd5, 32'h0, w_a5, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // FFT entry with ramp data, always ready; count stall cycles directly
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h100, ramp_word(), 1'b1, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < NS + 4; i++) begin
      if (stall_out) stall_cnt++;
      idle(1'b1);
    end
    chk("stall_cycles", stall_cnt, NS);
    chk("words_after_ramp", words_done, 16'd1);

    // Backpressure 1,0,0,...
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h3000, rand_word(), 1'b0, 1'b0);
    drain_run(1);
    idle(1'b1);

    // Both enables, with a second entry waiting behind the drain
    w_b = rand_word();
    step(1'b1, 1'b1, 1'b1, 3'd3, 32'h200, rand_word(), 1'b1, 1'b0);
    while (q.size() != 0) step(1'b1, 1'b0, 1'b1, 3'd6, 32'h0, w_b, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd6, 32'h0, w_b, 1'b1, 1'b0);
    idle(1'b1);

    // Reset while sample 10 is offered, then a fresh drain from idx 0
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h400, ramp_word(), 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h500, rand_word(), 1'b1, 1'b0);
    drain_run(2);
    idle(1'b1);

    // Address wrap at sample 16
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFF0, ramp_word(), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) idle(1'b1);
    chk("wrap_addr16", fft_addr, 32'h0);
    drain_run(0);
    idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, REGW'($urandom), $urandom, rand_word(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_writeback_drain.md
FFT_WRITEBACK_DRAIN -- requirements
Module: fft_writeback_drain

Interface
REQ-001 SHALL have parameter INW, default 512: width of the writeback data word.
REQ-002 SHALL have parameter DATAW, default 16: FFT sample width; NS = INW/DATAW samples per word (32 at defaults).
REQ-003 SHALL have parameter ADDRW, default 32: FFT buffer address width.
REQ-004 SHALL have parameter REGW, default 3: register index width.
REQ-005 SHALL have ports, one per line:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  writeback stage entry valid
- fft_wr_en_in  in  1  entry writes FFT buffer
- reg_wr_en_in  in  1  entry writes register file
- wr_reg_in  in  REGW  destination register
- addr_in  in  ADDRW  FFT buffer base sample address
- data_in  in  INW  writeback word
- stall_out  out  1  holds the writeback pipe register
- rf_wr_en  out  1  register-file write strobe
- rf_wr_reg  out  REGW  register-file write index
- rf_wr_data  out  INW  register-file write data
- fft_valid  out  1  sample offered to FFT buffer
- fft_ready  in  1  FFT buffer accepts sample
- fft_addr  out  ADDRW  sample address
- fft_data  out  DATAW  sample data
- fft_last  out  1  final sample of the word
- words_done  out  16  completed FFT word count

Function
REQ-006 SHALL implement a two-state FSM: IDLE, DRAIN.
REQ-007 stall_out SHALL equal (state == DRAIN), driven from registered state only.
REQ-008 In IDLE, an entry is consumed when valid_in=1; entries with valid_in=0 SHALL cause no write.
REQ-009 Consumed entry with reg_wr_en_in=1: on the next edge, rf_wr_en=1, rf_wr_reg=wr_reg_in, rf_wr_data=data_in, for exactly one cycle (1-cycle latency).
REQ-010 rf_wr_en SHALL be 0 in every other cycle; rf_wr_reg/rf_wr_data hold their last values.
REQ-011 Consumed entry with fft_wr_en_in=1: on the next edge, latch data_in and addr_in, clear sample index idx, enter DRAIN.
REQ-012 Entry with both enables set SHALL perform both REQ-009 and REQ-011 from the same edge.
REQ-013 In DRAIN: fft_valid=1; fft_data = latched word bits [idx*DATAW +: DATAW] (sample 0 = LSBs); fft_addr = latched base + idx, modulo 2^ADDRW; fft_last = (idx == NS-1).
REQ-014 fft_data, fft_addr, and fft_last SHALL remain stable while fft_valid=1 and fft_ready=0.
REQ-015 Each cycle with fft_valid && fft_ready SHALL increment idx; when fft_last=1, return to IDLE, increment words_done (wrapping 0xFFFF -> 0), and clear idx.
REQ-016 In IDLE, fft_valid and fft_last SHALL be 0.
REQ-017 In DRAIN, all *_in inputs SHALL be ignored; the held entry is consumed in the first IDLE cycle after DRAIN ends.
REQ-018 A drained word SHALL take exactly NS handshake cycles; with fft_ready held at 1, stall_out is high for NS cycles.

Reset
REQ-019 When rst=1 at an edge, the block SHALL enter IDLE with idx=0, words_done=0, rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, latched word/address=0, stall_out=0, and fft_valid=0.
REQ-020 Reset asserted mid-DRAIN SHALL abort the word: no further samples are offered and words_done is not incremented.
REQ-021 rst SHALL take priority over all other inputs.

Verification
REQ-022 Reg-only entry: wr_reg_in=5, data_in=0xA5..A5, valid -> next cycle rf_wr_en=1, rf_wr_reg=5, data matches; stall_out stays 0.
REQ-023 FFT entry: addr_in=0x100, data_in sample k=k, fft_ready=1 -> 32 samples at addrs 0x100..0x11F with data 0..31, fft_last on the 32nd, stall_out high 32 cycles, words_done=1.
REQ-024 Backpressure: fft_ready toggles 1,0,0,1,... -> no sample lost or duplicated; outputs stable while ready=0.
REQ-025 Both enables plus a second valid entry queued behind -> rf write in cycle 1, drain completes, and the queued entry is consumed in the first IDLE cycle.
REQ-026 rst at sample 10 of a drain -> fft_valid=0 next cycle, words_done unchanged at 0, and the next entry drains from idx 0.
REQ-027 addr_in=0xFFFFFFF0 -> sample addresses wrap to 0x0 at sample 16.
